// File: rtl/matmul_pkg.sv
// Shared constants and state encoding for the matmul output-side result writer.
package matmul_pkg;

    localparam int WIDTH          = 16;
    localparam int BLOCK_SIZE     = 2;
    localparam int CHUNK_SIZE     = BLOCK_SIZE * BLOCK_SIZE;
    localparam int ROW_SIZE_MAT_A = 16;
    localparam int COL_SIZE_MAT_B = 10;
    localparam int ROW_SIZE_MAT_C = ROW_SIZE_MAT_A / BLOCK_SIZE;
    localparam int COL_SIZE_MAT_C = COL_SIZE_MAT_B / BLOCK_SIZE;
    localparam int MAX_FLAG       = ROW_SIZE_MAT_C * COL_SIZE_MAT_C;
    localparam int ADDR_WIDTH     = $clog2(MAX_FLAG);
    localparam int TILE_W         = WIDTH * CHUNK_SIZE;
    localparam int CNT_W          = ADDR_WIDTH + 1;

    localparam logic [ADDR_WIDTH-1:0] RAM_DEPTH_A = ADDR_WIDTH'(MAX_FLAG);
    localparam logic [CNT_W-1:0]      LAST_COUNT  = CNT_W'(MAX_FLAG - 1);
    localparam logic [15:0]           LAST_COL    = 16'(COL_SIZE_MAT_C - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Row-major tile index, computed at 32 bits before narrowing to the RAM address.
    function automatic logic [ADDR_WIDTH-1:0] tile_index(input logic [15:0] row,
                                                         input logic [15:0] col);
        return ADDR_WIDTH'(32'(row) * 32'(COL_SIZE_MAT_C) + 32'(col));
    endfunction

endpackage

// File: rtl/matmul_result_writer_result_ram.sv
// Result tile store: one write port, one synchronous read-first read port.
module result_ram
    import matmul_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [TILE_W-1:0]     wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [TILE_W-1:0]     rd_data
);

    logic [TILE_W-1:0] mem [MAX_FLAG];

    always_ff @(posedge clk) begin
        if (we && (wr_addr < RAM_DEPTH_A)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Output register sees the pre-write array contents, giving read-first behaviour.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= (rd_addr < RAM_DEPTH_A) ? mem[rd_addr] : '0;
        end
    end

endmodule

// File: rtl/matmul_result_writer.sv
// Captures finished systolic-core tiles into the result RAM at their row-major C position.
//
//  state   | meaning
//  IDLE    | waiting for en before collecting
//  COLLECT | storing one tile per accumulator_done rising edge
//  DONE    | all tiles stored; further captures flag overflow_err
module matmul_result_writer
    import matmul_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clear,
    input  logic                  accumulator_done,
    input  logic [TILE_W-1:0]     in_tile,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [TILE_W-1:0]     rd_data,
    output logic                  rd_valid,
    output logic [15:0]           tile_row,
    output logic [15:0]           tile_col,
    output logic [CNT_W-1:0]      tile_count,
    output logic                  all_done,
    output logic                  overflow_err
);

    state_t                state;
    logic                  done_q;
    logic                  capture;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;

    assign capture = accumulator_done & ~done_q & en;
    assign wr_en   = (state == COLLECT) & capture & ~clear;
    assign wr_addr = tile_index(tile_row, tile_col);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            done_q       <= 1'b0;
            rd_valid     <= 1'b0;
            tile_row     <= '0;
            tile_col     <= '0;
            tile_count   <= '0;
            all_done     <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            done_q   <= accumulator_done;
            rd_valid <= rd_en;
            if (clear) begin
                state        <= IDLE;
                tile_row     <= '0;
                tile_col     <= '0;
                tile_count   <= '0;
                all_done     <= 1'b0;
                overflow_err <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (en) state <= COLLECT;
                    end
                    COLLECT: begin
                        if (capture) begin
                            tile_count <= tile_count + 1'b1;
                            if (tile_col == LAST_COL) begin
                                tile_col <= '0;
                                tile_row <= tile_row + 16'd1;
                            end else begin
                                tile_col <= tile_col + 16'd1;
                            end
                            if (tile_count == LAST_COUNT) begin
                                state    <= DONE;
                                all_done <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        if (capture) overflow_err <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    result_ram u_result_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wr_en),
        .wr_addr (wr_addr),
        .wr_data (in_tile),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_matmul_result_writer.sv
// Scoreboard bench for matmul_result_writer: reads push expected words, a monitor checks rd_data.
module tb_matmul_result_writer;
    import matmul_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  en = 1'b0;
    logic                  clear = 1'b0;
    logic                  accumulator_done = 1'b0;
    logic [TILE_W-1:0]     in_tile = '0;
    logic                  rd_en = 1'b0;
    logic [ADDR_WIDTH-1:0] rd_addr = '0;
    logic [TILE_W-1:0]     rd_data;
    logic                  rd_valid;
    logic [15:0]           tile_row;
    logic [15:0]           tile_col;
    logic [CNT_W-1:0]      tile_count;
    logic                  all_done;
    logic                  overflow_err;

    int n_pass  = 0;
    int n_total = 0;
    logic [TILE_W-1:0] exp_q [$];

    always #5 clk = ~clk;

    matmul_result_writer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .en               (en),
        .clear            (clear),
        .accumulator_done (accumulator_done),
        .in_tile          (in_tile),
        .rd_en            (rd_en),
        .rd_addr          (rd_addr),
        .rd_data          (rd_data),
        .rd_valid         (rd_valid),
        .tile_row         (tile_row),
        .tile_col         (tile_col),
        .tile_count       (tile_count),
        .all_done         (all_done),
        .overflow_err     (overflow_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [TILE_W-1:0] v);
        accumulator_done = 1'b1;
        in_tile = v;
        tick();
        accumulator_done = 1'b0;
        tick();
    endtask

    task automatic rd(input int addr, input logic [TILE_W-1:0] exp);
        rd_en = 1'b1;
        rd_addr = ADDR_WIDTH'(addr);
        exp_q.push_back(exp);
        tick();
        rd_en = 1'b0;
    endtask

    // Monitor: every rd_valid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && rd_valid) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL rd_unexpected: got rd_valid=1 data %0h expected no read", rd_data);
            end else begin
                check("rd_data", rd_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_tile_count", 64'(tile_count), 64'd0);
        check("rst_all_done", 64'(all_done), 64'd0);
        check("rst_overflow", 64'(overflow_err), 64'd0);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_rd_data", rd_data, 64'd0);
        rst_n = 1'b1;
        en = 1'b1;
        tick();

        // 1: fill all 40 tiles with their index
        for (int k = 0; k < 40; k++) begin
            check("pre_row", 64'(tile_row), 64'(k / 5));
            check("pre_col", 64'(tile_col), 64'(k % 5));
            pulse(TILE_W'(k));
        end
        check("fill_count", 64'(tile_count), 64'd40);
        check("fill_all_done", 64'(all_done), 64'd1);
        check("fill_overflow", 64'(overflow_err), 64'd0);
        for (int k = 0; k < 40; k++) rd(k, TILE_W'(k));

        // 3: capture after all_done
        pulse(64'hDEAD);
        check("ovf_flag", 64'(overflow_err), 64'd1);
        check("ovf_count", 64'(tile_count), 64'd40);
        rd(39, 64'd39);

        // 5: clear coincident with a capture edge
        clear = 1'b1;
        accumulator_done = 1'b1;
        in_tile = 64'h5555;
        tick();
        clear = 1'b0;
        accumulator_done = 1'b0;
        tick();
        check("clr_count", 64'(tile_count), 64'd0);
        check("clr_all_done", 64'(all_done), 64'd0);
        check("clr_overflow", 64'(overflow_err), 64'd0);
        check("clr_row", 64'(tile_row), 64'd0);
        check("clr_col", 64'(tile_col), 64'd0);
        rd(0, 64'd0);

        // 2: held-high accumulator_done stores exactly once
        accumulator_done = 1'b1;
        in_tile = 64'hAAAA_AAAA_AAAA_AAAA;
        repeat (5) tick();
        accumulator_done = 1'b0;
        tick();
        check("hold_count", 64'(tile_count), 64'd1);
        rd(0, 64'hAAAA_AAAA_AAAA_AAAA);
        rd(1, 64'd1);

        // 4: en low during a pulse
        for (int k = 1; k < 6; k++) pulse(TILE_W'(100 + k));
        check("pre_en_count", 64'(tile_count), 64'd6);
        en = 1'b0;
        pulse(64'hBAD);
        check("en0_count", 64'(tile_count), 64'd6);
        en = 1'b1;
        tick();
        check("en1_row", 64'(tile_row), 64'd1);
        check("en1_col", 64'(tile_col), 64'd1);
        pulse(64'h606);
        check("en1_count", 64'(tile_count), 64'd7);
        rd(6, 64'h606);
        rd(7, 64'd7);

        // 6: same-cycle read/write of addr 3 returns old data; out-of-range read
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) pulse(TILE_W'(200 + k));
        accumulator_done = 1'b1;
        in_tile = 64'h333;
        rd(3, 64'd103);
        accumulator_done = 1'b0;
        tick();
        rd(3, 64'h333);
        rd(45, 64'd0);
        rd(0, 64'd200);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL rd_timeout: got %0d outstanding reads expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
